bp_be_stride_prefetch_issuer: RTL and testbench

//  Consumer of the loop-inference packet: accepts {remaining iterations, load PC, effective

---
 rtl/bp_be_stride_prefetch_issuer.sv | 137 +++++++++++++
 tb/tb_bp_be_stride_prefetch_issuer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_stride_prefetch_issuer.sv
// Turns a loop-inference packet {iterations, pc, address, stride} into a paced stream of
// line-aligned prefetch requests, skipping consecutive requests that hit the same line.
module bp_be_stride_prefetch_issuer #(
    parameter int vaddr_width_p          = 39,
    parameter int output_range_p         = 8,
    parameter int effective_addr_width_p = vaddr_width_p,
    parameter int stride_width_p         = 8,
    parameter int max_prefetch_p         = 16,
    parameter int issue_gap_p            = 2,
    parameter int line_offset_width_p    = 6
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [output_range_p-1:0]         remaining_iters_i,
    input  logic [vaddr_width_p-1:0]          pc_i,
    input  logic [effective_addr_width_p-1:0] eff_addr_i,
    input  logic [stride_width_p-1:0]         stride_i,
    input  logic                              v_i,
    output logic                              yumi_o,
    input  logic                              flush_i,
    output logic [effective_addr_width_p-1:0] pf_addr_o,
    output logic [vaddr_width_p-1:0]          pf_pc_o,
    output logic                              pf_v_o,
    input  logic                              pf_ready_i,
    output logic                              busy_o
);

    localparam int AW = effective_addr_width_p;
    localparam int LW = line_offset_width_p;
    localparam int CW = $clog2(max_prefetch_p + 1);
    localparam int GW = (issue_gap_p < 1) ? 1 : $clog2(issue_gap_p + 1);

    typedef enum logic [1:0] {E_IDLE, E_ISSUE, E_GAP} state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              count_q, count_d;
    logic [GW-1:0]              gap_q, gap_d;
    logic [AW-1:0]              next_addr_q, next_addr_d;
    logic [AW-LW-1:0]           last_line_q, last_line_d;
    logic                       last_line_v_q, last_line_v_d;
    logic [vaddr_width_p-1:0]   pc_q, pc_d;
    logic [stride_width_p-1:0]  stride_q, stride_d;

    logic          dup;
    logic          accept;
    logic [CW-1:0] iters_capped;
    logic [AW-1:0] stride_ext;
    logic [AW-1:0] in_stride_ext;

    assign stride_ext    = AW'($signed(stride_q));
    assign in_stride_ext = AW'($signed(stride_i));
    assign dup           = last_line_v_q && (next_addr_q[AW-1:LW] == last_line_q);
    assign accept        = (state_q == E_IDLE) && v_i && !flush_i && !reset_i;
    assign iters_capped  = (32'(remaining_iters_i) > 32'(max_prefetch_p))
                         ? CW'(max_prefetch_p) : CW'(remaining_iters_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= E_IDLE;
            count_q       <= '0;
            gap_q         <= '0;
            next_addr_q   <= '0;
            last_line_q   <= '0;
            last_line_v_q <= 1'b0;
            pc_q          <= '0;
            stride_q      <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            gap_q         <= gap_d;
            next_addr_q   <= next_addr_d;
            last_line_q   <= last_line_d;
            last_line_v_q <= last_line_v_d;
            pc_q          <= pc_d;
            stride_q      <= stride_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        gap_d         = gap_q;
        next_addr_d   = next_addr_q;
        last_line_d   = last_line_q;
        last_line_v_d = last_line_v_q;
        pc_d          = pc_q;
        stride_d      = stride_q;
        case (state_q)
            E_IDLE: begin
                if (accept) begin
                    pc_d          = pc_i;
                    stride_d      = stride_i;
                    count_d       = iters_capped;
                    next_addr_d   = eff_addr_i + in_stride_ext;
                    last_line_v_d = 1'b0;
                    // Zero-length or zero-stride streams are consumed but produce nothing.
                    if (iters_capped != '0 && stride_i != '0) state_d = E_ISSUE;
                end
            end
            E_ISSUE: begin
                if (dup) begin
                    next_addr_d = next_addr_q + stride_ext;
                    count_d     = count_q - CW'(1);
                    if (count_q == CW'(1)) state_d = E_IDLE;
                end else if (pf_ready_i) begin
                    last_line_d   = next_addr_q[AW-1:LW];
                    last_line_v_d = 1'b1;
                    next_addr_d   = next_addr_q + stride_ext;
                    count_d       = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = E_IDLE;
                    end else if (issue_gap_p == 0) begin
                        state_d = E_ISSUE;
                    end else begin
                        state_d = E_GAP;
                        gap_d   = GW'(issue_gap_p);
                    end
                end
            end
            E_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) state_d = E_ISSUE;
            end
            default: state_d = E_IDLE;
        endcase
        if (flush_i) state_d = E_IDLE;
    end

    always_comb begin
        yumi_o    = accept;
        pf_v_o    = (state_q == E_ISSUE) && !dup;
        pf_addr_o = {next_addr_q[AW-1:LW], {LW{1'b0}}};
        pf_pc_o   = pc_q;
        busy_o    = (state_q != E_IDLE);
    end

endmodule

// File: tb/tb_bp_be_stride_prefetch_issuer.sv
// Directed bench for the stride prefetch issuer: one task per scenario, handshakes logged by a monitor.
module tb_bp_be_stride_prefetch_issuer;

    localparam int AW = 39;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    iters;
    logic [AW-1:0] pc;
    logic [AW-1:0] eff;
    logic [7:0]    stride;
    logic          v;
    logic          yumi_o;
    logic          flush;
    logic [AW-1:0] pf_addr_o;
    logic [AW-1:0] pf_pc_o;
    logic          pf_v_o;
    logic          ready;
    logic          busy_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [AW-1:0] q_addr[$];
    logic [AW-1:0] q_pc[$];
    int            q_cyc[$];

    bp_be_stride_prefetch_issuer dut (
        .clk_i(clk), .reset_i(rst), .remaining_iters_i(iters), .pc_i(pc),
        .eff_addr_i(eff), .stride_i(stride), .v_i(v), .yumi_o(yumi_o), .flush_i(flush),
        .pf_addr_o(pf_addr_o), .pf_pc_o(pf_pc_o), .pf_v_o(pf_v_o),
        .pf_ready_i(ready), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && pf_v_o && ready) begin
            q_addr.push_back(pf_addr_o);
            q_pc.push_back(pf_pc_o);
            q_cyc.push_back(cyc);
            $display("[%0d] pf addr=%h pc=%h", cyc, pf_addr_o, pf_pc_o);
        end
    end

    task automatic clear_log();
        q_addr.delete();
        q_pc.delete();
        q_cyc.delete();
    endtask

    task automatic send(input logic [AW-1:0] e, input logic [7:0] s, input logic [7:0] it,
                        input logic [AW-1:0] p, output logic y);
        @(posedge clk); #1;
        eff = e; stride = s; iters = it; pc = p; v = 1'b1;
        @(negedge clk);
        y = yumi_o;
        $display("[%0d] pkt eff=%h stride=%h iters=%0d yumi=%b", cyc, e, s, it, y);
        @(posedge clk); #1;
        v = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; v = 1'b1; flush = 1'b0; ready = 1'b1;
        iters = 8'd3; pc = '0; eff = '0; stride = 8'd64;
        #2;
        checks++; if (yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi got=%b exp=0", yumi_o); end
        checks++; if (pf_v_o !== 1'b0) begin errors++; $display("FAIL reset_pf_v got=%b exp=0", pf_v_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (pf_addr_o !== '0 || pf_pc_o !== '0) begin
            errors++; $display("FAIL reset_addr_pc got=%h/%h exp=0/0", pf_addr_o, pf_pc_o);
        end
        v = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_stream();
        logic [AW-1:0] exp_a[3] = '{39'h1040, 39'h1080, 39'h10C0};
        logic y; bit ok;
        clear_log();
        send(39'h1000, 8'd64, 8'd3, 39'h400, y);
        checks++; if (y !== 1'b1) begin errors++; $display("FAIL basic_yumi got=%b exp=1", y); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=busy exp=idle"); end
        checks++; if (q_addr.size() != 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", q_addr.size()); end
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== exp_a[i]) begin errors++; $display("FAIL basic_addr%0d got=%h exp=%h", i, q_addr[i], exp_a[i]); end
        end
        for (int i = 1; i < 3 && i < q_cyc.size(); i++) begin
            checks++; if (q_cyc[i] - q_cyc[i-1] != 3) begin errors++; $display("FAIL basic_spacing%0d got=%0d exp=3", i, q_cyc[i] - q_cyc[i-1]); end
        end
    endtask

    task automatic test_negative_stride();
        logic [AW-1:0] exp_a[2] = '{39'h1FC0, 39'h1F80};
        logic y; bit ok;
        clear_log();
        send(39'h2000, 8'hC0, 8'd2, 39'h7A5C, y);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL neg_timeout got=busy exp=idle"); end
        checks++; if (q_addr.size() != 2) begin errors++; $display("FAIL neg_count got=%0d exp=2", q_addr.size()); end
        for (int i = 0; i < 2 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== exp_a[i]) begin errors++; $display("FAIL neg_addr%0d got=%h exp=%h", i, q_addr[i], exp_a[i]); end
            checks++; if (q_pc[i] !== 39'h7A5C) begin errors++; $display("FAIL neg_pc%0d got=%h exp=%h", i, q_pc[i], 39'h7A5C); end
        end
    endtask

    task automatic test_dup_skip();
        logic [AW-1:0] exp_a[3] = '{39'h1000, 39'h1040, 39'h1080};
        logic y; bit ok;
        clear_log();
        send(39'h1000, 8'd16, 8'd8, 39'h500, y);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL dup_timeout got=busy exp=idle"); end
        checks++; if (q_addr.size() != 3) begin errors++; $display("FAIL dup_count got=%0d exp=3", q_addr.size()); end
        for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
            checks++; if (q_addr[i] !== exp_a[i]) begin errors++; $display("FAIL dup_addr%0d got=%h exp=%h", i, q_addr[i], exp_a[i]); end
        end
    endtask

    task automatic test_cap_and_zero();
        logic y; bit ok;
        clear_log();
        send(39'h6000, 8'd64, 8'd200, 39'h600, y);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL cap_timeout got=busy exp=idle"); end
        checks++; if (q_addr.size() != 16) begin errors++; $display("FAIL cap_count got=%0d exp=16", q_addr.size()); end
        if (q_addr.size() == 16) begin
            checks++; if (q_addr[0] !== 39'h6040) begin errors++; $display("FAIL cap_first got=%h exp=%h", q_addr[0], 39'h6040); end
            checks++; if (q_addr[15] !== 39'h6400) begin errors++; $display("FAIL cap_last got=%h exp=%h", q_addr[15], 39'h6400); end
        end
        clear_log();
        send(39'h7000, 8'd64, 8'd0, 39'h700, y);
        checks++; if (y !== 1'b1) begin errors++; $display("FAIL zero_yumi got=%b exp=1", y); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (busy_o !== 1'b0 || pf_v_o !== 1'b0) begin
                errors++; $display("FAIL zero_idle busy/pf_v got=%b/%b exp=0/0", busy_o, pf_v_o);
            end
        end
        checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL zero_count got=%0d exp=0", q_addr.size()); end
    endtask

    task automatic test_backpressure();
        logic y; bit ok;
        clear_log();
        ready = 1'b0;
        send(39'h5000, 8'd64, 8'd2, 39'h800, y);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h5040) begin
                errors++; $display("FAIL bp_hold%0d pf_v/addr got=%b/%h exp=1/%h", i, pf_v_o, pf_addr_o, 39'h5040);
            end
        end
        @(posedge clk); #1;
        ready = 1'b1;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=busy exp=idle"); end
        checks++; if (q_addr.size() != 2) begin errors++; $display("FAIL bp_count got=%0d exp=2", q_addr.size()); end
        if (q_addr.size() == 2) begin
            checks++; if (q_addr[0] !== 39'h5040 || q_addr[1] !== 39'h5080) begin
                errors++; $display("FAIL bp_addr got=%h,%h exp=%h,%h", q_addr[0], q_addr[1], 39'h5040, 39'h5080);
            end
        end
    endtask

    task automatic test_flush();
        logic y; bit ok;
        bit seen = 1'b0;
        clear_log();
        send(39'h3000, 8'd64, 8'd5, 39'h900, y);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q_addr.size() >= 2) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL flush_wait got=%0d exp=2 requests", q_addr.size()); end
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || pf_v_o !== 1'b0) begin
            errors++; $display("FAIL flush_idle busy/pf_v got=%b/%b exp=0/0", busy_o, pf_v_o);
        end
        checks++; if (q_addr.size() != 2) begin errors++; $display("FAIL flush_count got=%0d exp=2", q_addr.size()); end
        clear_log();
        send(39'h4000, 8'd64, 8'd1, 39'hA00, y);
        checks++; if (y !== 1'b1) begin errors++; $display("FAIL flush_new_yumi got=%b exp=1", y); end
        wait_idle(ok);
        checks++; if (q_addr.size() != 1 || !ok) begin
            errors++; $display("FAIL flush_new_count got=%0d exp=1", q_addr.size());
        end else begin
            checks++; if (q_addr[0] !== 39'h4040) begin errors++; $display("FAIL flush_new_addr got=%h exp=%h", q_addr[0], 39'h4040); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_negative_stride();
        test_dup_skip();
        test_cap_and_zero();
        test_backpressure();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
